// File: rtl/spi_rx_deserializer_if.sv
// Link and consumer signals of the SPI receive deserializer, grouped so the
// receiver binds as one port.
// Handshake: dout transfers on a clk edge where out_valid & out_ready are both 1;
// out_valid never drops and dout never changes while a word waits for out_ready.
interface spi_rx_deserializer_if #(
  parameter int DATA_W = 12
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic [DATA_W-1:0] dout;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;

  modport master (
    output sclk, cs, mosi, out_ready,
    input  dout, out_valid, frame_err, overrun
  );

  modport slave (
    input  sclk, cs, mosi, out_ready,
    output dout, out_valid, frame_err, overrun
  );
endinterface

// File: rtl/spi_rx_deserializer.sv
// Oversampling receiver for the LSB-first SPI link: resynchronizes sclk/cs/mosi,
// rebuilds each frame and offers it on a one-word valid/ready holding register.
module spi_rx_deserializer #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  spi_rx_deserializer_if.slave        bus,
  output logic [1:0]                  dbg_state
);
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, WAIT_CS} state_t;

  state_t              state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                sclk_d, cs_d;
  logic                sclk_s, cs_s, mosi_s;
  logic                sclk_fall, cs_fall, cs_rise;
  logic [PRIME_W-1:0]  prime_cnt;
  logic                cs_seen_high;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-2:0]   shreg;
  logic [DATA_W-1:0]   word;
  logic                done;
  logic [DATA_W-1:0]   done_word;
  logic                start, shift_en, last_bit, err;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign word      = {mosi_s, shreg};
  assign dbg_state = state;

  // cs_seen_high only trusts cs_s once the reset values have drained out of the
  // chain, so a link held low across reset cannot fake a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync    <= '0;
      cs_sync      <= '1;
      mosi_sync    <= '0;
      sclk_d       <= 1'b0;
      cs_d         <= 1'b1;
      prime_cnt    <= '0;
      cs_seen_high <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (prime_cnt != PRIME_MAX) prime_cnt <= prime_cnt + 1'b1;
      if (prime_cnt == PRIME_MAX && cs_s) cs_seen_high <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    last_bit  = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && cs_seen_high) begin
          start     = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (cs_rise) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_fall) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // A final fall coinciding with cs_rise still completes the word.
        if (sclk_fall) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            last_bit  = 1'b1;
            state_nxt = cs_rise ? IDLE : WAIT_CS;
          end else if (cs_rise) begin
            err       = 1'b1;
            state_nxt = IDLE;
          end
        end else if (cs_rise) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_CS: begin
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      done          <= 1'b0;
      done_word     <= '0;
      bus.dout      <= '0;
      bus.out_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      state         <= state_nxt;
      done          <= last_bit;
      bus.frame_err <= err;
      bus.overrun   <= 1'b0;
      if (start) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= word[DATA_W-1:1];
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (last_bit) done_word <= word;
      // Delivery stage: a completed word either lands in the holding register
      // or is dropped with an overrun pulse when the consumer is stalled.
      if (done) begin
        if (!bus.out_valid || bus.out_ready) begin
          bus.dout      <= done_word;
          bus.out_valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed bench for spi_rx_deserializer: drives the SPI link as the master does
// and checks delivered words, flags and latency against hand-computed values.
module tb_spi_rx_deserializer;
  localparam int DATA_W = 12;
  localparam int H      = 6;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  spi_rx_deserializer_if #(.DATA_W(DATA_W)) bus ();

  spi_rx_deserializer #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // monitor: consumed words and flag-high cycles, sampled on the falling edge
  logic [DATA_W-1:0] got_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vc_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.dout);
      if (bus.out_valid) vc_cnt++;
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun) ov_cnt++;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Dummy sclk cycle first, then nbits data cycles; lat = edges from the last
  // sclk fall until out_valid is seen (0 if it never rose within the window).
  task automatic send_frame(input logic [DATA_W-1:0] w, input int nbits, output int lat);
    lat = 0;
    bus.cs = 1'b0;
    tick(H);
    for (int i = 0; i <= nbits; i++) begin
      bus.sclk = 1'b1;
      bus.mosi = (i == 0) ? 1'b0 : w[i-1];
      tick(H);
      bus.sclk = 1'b0;
      if (i == nbits) begin
        for (int k = 1; k <= H; k++) begin
          tick(1);
          if (bus.out_valid && lat == 0) lat = k;
        end
      end else begin
        tick(H);
      end
    end
    bus.cs = 1'b1;
    tick(2 * H);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);
    check("reset_dout", 32'(bus.dout), 32'h0);
    check("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_overrun", 32'(bus.overrun), 32'h0);
    rst = 1'b0;
    tick(8);
  endtask

  task automatic test_single();
    int base_q, base_fe, base_ov, base_vc, lat;
    base_q = got_q.size(); base_fe = fe_cnt; base_ov = ov_cnt; base_vc = vc_cnt;
    bus.out_ready = 1'b1;
    send_frame(12'hA5C, DATA_W, lat);
    check("single_count", 32'(got_q.size() - base_q), 32'd1);
    if (got_q.size() > base_q) check("single_word", 32'(got_q[base_q]), 32'hA5C);
    check("single_valid_cycles", 32'(vc_cnt - base_vc), 32'd1);
    check("single_latency", 32'(lat), 32'd4);
    check("single_frame_err", 32'(fe_cnt - base_fe), 32'd0);
    check("single_overrun", 32'(ov_cnt - base_ov), 32'd0);
  endtask

  task automatic test_back_to_back();
    int base_q, lat;
    base_q = got_q.size();
    bus.out_ready = 1'b1;
    send_frame(12'h001, DATA_W, lat);
    send_frame(12'h800, DATA_W, lat);
    check("b2b_count", 32'(got_q.size() - base_q), 32'd2);
    if (got_q.size() >= base_q + 2) begin
      check("b2b_word0", 32'(got_q[base_q]), 32'h001);
      check("b2b_word1", 32'(got_q[base_q+1]), 32'h800);
    end
  endtask

  task automatic test_overrun();
    int base_q, base_ov, base_fe, lat;
    base_q = got_q.size(); base_ov = ov_cnt; base_fe = fe_cnt;
    bus.out_ready = 1'b0;
    send_frame(12'h123, DATA_W, lat);
    send_frame(12'h456, DATA_W, lat);
    check("ovr_held_valid", 32'(bus.out_valid), 32'h1);
    check("ovr_held_dout", 32'(bus.dout), 32'h123);
    check("ovr_pulses", 32'(ov_cnt - base_ov), 32'd1);
    check("ovr_no_consume", 32'(got_q.size() - base_q), 32'd0);
    bus.out_ready = 1'b1;
    tick(1);
    check("ovr_drained_valid", 32'(bus.out_valid), 32'h0);
    tick(5);
    check("ovr_consumed_count", 32'(got_q.size() - base_q), 32'd1);
    if (got_q.size() > base_q) check("ovr_consumed_word", 32'(got_q[base_q]), 32'h123);
    check("ovr_frame_err", 32'(fe_cnt - base_fe), 32'd0);
  endtask

  task automatic test_frame_err();
    int base_q, base_fe, base_ov, lat;
    base_q = got_q.size(); base_fe = fe_cnt; base_ov = ov_cnt;
    bus.out_ready = 1'b1;
    send_frame(12'hFFF, 4, lat);
    check("ferr_pulse", 32'(fe_cnt - base_fe), 32'd1);
    check("ferr_no_word", 32'(got_q.size() - base_q), 32'd0);
    check("ferr_no_overrun", 32'(ov_cnt - base_ov), 32'd0);
    send_frame(12'hFFF, DATA_W, lat);
    check("ferr_next_count", 32'(got_q.size() - base_q), 32'd1);
    if (got_q.size() > base_q) check("ferr_next_word", 32'(got_q[base_q]), 32'hFFF);
  endtask

  task automatic test_reset_mid_frame();
    int base_q, base_fe, lat;
    logic [DATA_W-1:0] w;
    w = 12'h3C3;
    base_q = got_q.size(); base_fe = fe_cnt;
    bus.out_ready = 1'b1;
    bus.cs = 1'b0;
    tick(H);
    for (int i = 0; i <= 6; i++) begin
      bus.sclk = 1'b1;
      bus.mosi = (i == 0) ? 1'b0 : w[i-1];
      tick(H);
      bus.sclk = 1'b0;
      tick(H);
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(H);
    bus.cs = 1'b1;
    tick(2 * H);
    check("rstmid_no_word", 32'(got_q.size() - base_q), 32'd0);
    check("rstmid_no_frame_err", 32'(fe_cnt - base_fe), 32'd0);
    check("rstmid_valid_low", 32'(bus.out_valid), 32'h0);
    send_frame(12'h555, DATA_W, lat);
    check("rstmid_next_count", 32'(got_q.size() - base_q), 32'd1);
    if (got_q.size() > base_q) check("rstmid_next_word", 32'(got_q[base_q]), 32'h555);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
